// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the I-cache (port 0) and D-cache (port 1) controllers and one RAM port.
// Every output is registered; a wait counter bounds how long a grant may wait for the RAM.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_MemRead,
  input  logic              p0_MemWrite,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ready,
  output logic              p0_err,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_MemRead,
  input  logic              p1_MemWrite,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ready,
  output logic              p1_err,
  output logic [ADDR_W-1:0] arb2mem_addr,
  output logic [DATA_W-1:0] arb2mem_data,
  output logic              arb2mem_MemRead,
  output logic              arb2mem_MemWrite,
  input  logic [DATA_W-1:0] mem2arb_data_in,
  input  logic              mem2arb_ready
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state, state_nxt;
  logic              last_grant, last_grant_nxt;
  logic [7:0]        wait_cnt, wait_cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt, p0_rdata_nxt, p1_rdata_nxt;
  logic              rd_nxt, wr_nxt;
  logic              p0_ready_nxt, p1_ready_nxt, p0_err_nxt, p1_err_nxt;
  logic              pend0, pend1, pick, done, timeout;

  assign pend0 = p0_MemRead | p0_MemWrite;
  assign pend1 = p1_MemRead | p1_MemWrite;
  // With both pending, the port that did not win last time goes next.
  assign pick  = (pend0 && pend1) ? ~last_grant : pend1;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    wait_cnt_nxt   = wait_cnt;
    addr_nxt       = arb2mem_addr;
    data_nxt       = arb2mem_data;
    rd_nxt         = arb2mem_MemRead;
    wr_nxt         = arb2mem_MemWrite;
    p0_rdata_nxt   = p0_rdata;
    p1_rdata_nxt   = p1_rdata;
    p0_ready_nxt   = 1'b0;
    p1_ready_nxt   = 1'b0;
    p0_err_nxt     = 1'b0;
    p1_err_nxt     = 1'b0;
    done           = 1'b0;
    timeout        = 1'b0;
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          state_nxt      = pick ? GRANT1 : GRANT0;
          last_grant_nxt = pick;
          wait_cnt_nxt   = '0;
          addr_nxt       = pick ? p1_addr : p0_addr;
          data_nxt       = pick ? p1_wdata : p0_wdata;
          wr_nxt         = pick ? p1_MemWrite : p0_MemWrite;
          rd_nxt         = ~wr_nxt;
        end
      end
      GRANT0, GRANT1: begin
        // A ready arriving on the last allowed cycle still counts as a normal completion.
        if (!mem2arb_ready) begin
          wait_cnt_nxt = wait_cnt + 8'd1;
          timeout      = (wait_cnt == WAIT_LAST);
        end
        done = mem2arb_ready || timeout;
        if (done) begin
          state_nxt = IDLE;
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          if (state == GRANT0) begin
            p0_ready_nxt = 1'b1;
            p0_err_nxt   = timeout;
            if (arb2mem_MemRead && !timeout) p0_rdata_nxt = mem2arb_data_in;
          end else begin
            p1_ready_nxt = 1'b1;
            p1_err_nxt   = timeout;
            if (arb2mem_MemRead && !timeout) p1_rdata_nxt = mem2arb_data_in;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      wait_cnt         <= '0;
      arb2mem_addr     <= '0;
      arb2mem_data     <= '0;
      arb2mem_MemRead  <= 1'b0;
      arb2mem_MemWrite <= 1'b0;
      p0_rdata         <= '0;
      p1_rdata         <= '0;
      p0_ready         <= 1'b0;
      p1_ready         <= 1'b0;
      p0_err           <= 1'b0;
      p1_err           <= 1'b0;
    end else begin
      state            <= state_nxt;
      last_grant       <= last_grant_nxt;
      wait_cnt         <= wait_cnt_nxt;
      arb2mem_addr     <= addr_nxt;
      arb2mem_data     <= data_nxt;
      arb2mem_MemRead  <= rd_nxt;
      arb2mem_MemWrite <= wr_nxt;
      p0_rdata         <= p0_rdata_nxt;
      p1_rdata         <= p1_rdata_nxt;
      p0_ready         <= p0_ready_nxt;
      p1_ready         <= p1_ready_nxt;
      p0_err           <= p0_err_nxt;
      p1_err           <= p1_err_nxt;
    end
  end

endmodule
